fetch_redirect_ctrl: RTL and testbench

//  Pre-IF next-PC generator, the consuming end of ID's branch resolve signals (br_taken/br_target/br_stall).

---
 rtl/fetch_redirect_ctrl_pkg.sv | 22 ++
 rtl/fetch_redirect_ctrl_inflight_tracker.sv | 38 +++
 rtl/fetch_redirect_ctrl.sv | 93 +++++++++
 tb/tb_fetch_redirect_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types and constants for the pre-IF fetch redirect controller.
package fetch_redirect_ctrl_pkg;

    typedef logic [31:0] virt_t;
    typedef logic [31:0] uint32_t;
    typedef logic [1:0]  cnt_t;

    localparam virt_t DEFAULT_RESET_PC = 32'hbfc0_0000;

    typedef enum logic [1:0] {
        SEQ        = 2'd0,
        BR_WAIT_DS = 2'd1,
        BR_PEND    = 2'd2,
        FLUSH      = 2'd3
    } fetch_state_t;

    // Sequential successor; wraps mod 2^32, alignment is IF's concern.
    function automatic virt_t pc_inc(input virt_t pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_inflight_tracker.sv
// Counts accepted-but-unanswered fetches and marks responses that belong
// to requests issued before the most recent flush so IF can discard them.
module fetch_redirect_ctrl_inflight_tracker
    import fetch_redirect_ctrl_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic accept,
    input  logic data_ok,
    input  logic flush,
    output cnt_t inflight,
    output logic resp_valid,
    output logic resp_drop
);

    cnt_t discard;

    // Responses arrive in order, so the oldest 'discard' of them are stale.
    assign resp_drop  = resetn && data_ok && (discard != 2'd0);
    assign resp_valid = resetn && data_ok && (discard == 2'd0);

    // Outstanding-request and stale-response counters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inflight <= 2'd0;
            discard  <= 2'd0;
        end else begin
            inflight <= inflight + cnt_t'(accept) - cnt_t'(data_ok);
            // A flush condemns everything still outstanding after this cycle's
            // response; a later flush simply recomputes from the live count.
            if (flush)
                discard <= inflight - cnt_t'(data_ok);
            else if (resp_drop)
                discard <= discard - 2'd1;
        end
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Pre-IF next-PC generator: in-order SRAM-like fetch issue, MIPS delay-slot
// ordering for taken branches, and WB flush redirects with stale-response drop.
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter virt_t RESET_PC     = DEFAULT_RESET_PC,
    parameter int    MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_taken,
    input  logic        br_stall,
    input  logic [31:0] br_target,
    input  logic        fs_valid,
    input  logic        fs_allowin,
    input  logic        wb_flush,
    input  logic [31:0] flush_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    output logic        resp_valid,
    output logic        resp_drop
);

    localparam cnt_t MAX_CNT = cnt_t'(MAX_INFLIGHT);

    fetch_state_t state;
    virt_t        pc;
    virt_t        tgt;
    cnt_t         inflight;
    logic         accept;
    logic         br_go;

    // Request is held low during reset and in the flush cycle itself.
    assign inst_req  = resetn && fs_allowin && !wb_flush && (inflight < MAX_CNT);
    assign inst_addr = (state == BR_PEND || state == FLUSH) ? tgt : pc;
    assign accept    = inst_req && inst_addr_ok;
    assign br_go     = br_taken && !br_stall;

    // Next-PC state machine; flush overrides any branch activity.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= SEQ;
            pc    <= RESET_PC;
            tgt   <= '0;
        end else if (wb_flush) begin
            tgt   <= flush_target;
            state <= FLUSH;
        end else begin
            case (state)
                SEQ: begin
                    if (br_go) begin
                        tgt <= br_target;
                        // pc is the delay slot when IF does not hold it yet;
                        // if it is being accepted right now the target is next.
                        if (fs_valid || accept)
                            state <= BR_PEND;
                        else
                            state <= BR_WAIT_DS;
                    end else if (accept) begin
                        pc <= pc_inc(pc);
                    end
                end
                BR_WAIT_DS: begin
                    if (accept) begin
                        pc    <= tgt;
                        state <= SEQ;
                    end
                end
                BR_PEND, FLUSH: begin
                    if (accept) begin
                        pc    <= pc_inc(tgt);
                        state <= SEQ;
                    end
                end
                default: state <= SEQ;
            endcase
        end
    end

    fetch_redirect_ctrl_inflight_tracker u_tracker (
        .clk        (clk),
        .resetn     (resetn),
        .accept     (accept),
        .data_ok    (inst_data_ok),
        .flush      (wb_flush),
        .inflight   (inflight),
        .resp_valid (resp_valid),
        .resp_drop  (resp_drop)
    );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed vector bench for fetch_redirect_ctrl.
module tb_fetch_redirect_ctrl;

    localparam logic [31:0] B = 32'hbfc0_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        br_taken, br_stall, fs_valid, fs_allowin, wb_flush;
    logic [31:0] br_target, flush_target;
    logic        inst_req, inst_addr_ok, inst_data_ok, resp_valid, resp_drop;
    logic [31:0] inst_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .br_taken     (br_taken),
        .br_stall     (br_stall),
        .br_target    (br_target),
        .fs_valid     (fs_valid),
        .fs_allowin   (fs_allowin),
        .wb_flush     (wb_flush),
        .flush_target (flush_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .resp_valid   (resp_valid),
        .resp_drop    (resp_drop)
    );

    typedef struct {
        logic        rst;
        logic        bt;
        logic        bs;
        logic [31:0] btgt;
        logic        fv;
        logic        fl;
        logic [31:0] ftgt;
        logic        fa;
        logic        ok;
        logic        dok;
        logic        req;
        logic [31:0] addr;
        logic        rv;
        logic        rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic bt, input logic bs,
                                input logic [31:0] btgt, input logic fv, input logic fl,
                                input logic [31:0] ftgt, input logic fa, input logic ok,
                                input logic dok, input logic req, input logic [31:0] addr,
                                input logic rv, input logic rd);
        vec_t v;
        v.rst = rst; v.bt = bt; v.bs = bs; v.btgt = btgt; v.fv = fv; v.fl = fl;
        v.ftgt = ftgt; v.fa = fa; v.ok = ok; v.dok = dok;
        v.req = req; v.addr = addr; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic req, input logic [31:0] addr,
                            input logic rv, input logic rd);
        chk({tag, ".inst_req"},   {31'd0, inst_req},   {31'd0, req});
        chk({tag, ".inst_addr"},  inst_addr,           addr);
        chk({tag, ".resp_valid"}, {31'd0, resp_valid}, {31'd0, rv});
        chk({tag, ".resp_drop"},  {31'd0, resp_drop},  {31'd0, rd});
    endtask

    task automatic idle_inputs();
        br_taken = 0; br_stall = 0; br_target = '0; fs_valid = 0;
        fs_allowin = 1; wb_flush = 0; flush_target = '0;
        inst_addr_ok = 0; inst_data_ok = 0;
    endtask

    initial begin
        // rst bt bs btgt       fv fl ftgt          fa ok dok | req addr        rv rd
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,0, 1,B,          0,0)); // seq 00
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+4,        1,0)); // seq 04
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+8,        1,0)); // seq 08
        vecs.push_back(mk(1,0,0,0,        0,0,0,             1,1,1, 0,B,          0,0)); // reset
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,0, 1,B,          0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+4,        1,0)); // delay slot out
        vecs.push_back(mk(0,1,0,B+'h100,  1,0,0,             1,0,1, 1,B+8,        1,0)); // br, fs_valid
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,0, 1,B+'h100,    0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+'h104,    1,0));
        vecs.push_back(mk(1,0,0,0,        0,0,0,             1,1,1, 0,B,          0,0)); // reset
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,0, 1,B,          0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+4,        1,0));
        vecs.push_back(mk(0,1,0,B+'h200,  0,0,0,             1,0,1, 1,B+8,        1,0)); // br, no ds
        vecs.push_back(mk(0,1,0,B+'h300,  0,0,0,             1,1,0, 1,B+8,        0,0)); // ds issue, 2nd br ignored
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+'h200,    1,0));
        vecs.push_back(mk(0,1,1,0,        0,0,0,             1,1,1, 1,B+'h204,    1,0)); // stalled br
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+'h208,    1,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,0, 1,B+'h20c,    0,0)); // inflight -> 2
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,0, 0,B+'h210,    0,0)); // full
        vecs.push_back(mk(0,0,0,0,        0,1,B+'h380,       1,1,0, 0,B+'h210,    0,0)); // flush, 2 stale
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 0,B+'h380,    0,1));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+'h380,    0,1));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+'h384,    1,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,0,1, 1,B+'h388,    1,0));
        vecs.push_back(mk(0,1,0,B+'h500,  0,0,0,             1,0,0, 1,B+'h388,    0,0)); // -> wait ds
        vecs.push_back(mk(0,1,0,B+'h700,  0,1,B+'h600,       1,1,0, 0,B+'h388,    0,0)); // flush beats br
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,0, 1,B+'h600,    0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+'h604,    1,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,0, 1,B+'h608,    0,0));
        vecs.push_back(mk(0,0,0,0,        0,1,B+'h800,       1,1,1, 0,B+'h60c,    1,0)); // flush 1
        vecs.push_back(mk(0,0,0,0,        0,1,B+'h900,       1,1,0, 0,B+'h800,    0,0)); // flush 2 wins
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,1, 1,B+'h900,    0,1));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,0,1, 1,B+'h904,    1,0));
        vecs.push_back(mk(0,0,0,0,        0,1,32'hffff_fffc, 1,1,0, 0,B+'h904,    0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,0, 1,32'hffff_fffc,0,0));
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,0,1, 1,32'h0,      1,0)); // wrapped
        vecs.push_back(mk(0,0,0,0,        0,0,0,             0,1,0, 0,32'h0,      0,0)); // !allowin
        vecs.push_back(mk(1,0,0,0,        0,0,0,             1,1,1, 0,B,          0,0)); // reset
        vecs.push_back(mk(0,0,0,0,        0,0,0,             1,1,0, 1,B,          0,0));

        resetn = 0;
        idle_inputs();
        inst_data_ok = 1;
        @(negedge clk);
        chk_outs("reset_state", 0, B, 0, 0);
        @(posedge clk); #1;
        resetn = 1;

        foreach (vecs[i]) begin
            resetn       = !vecs[i].rst;
            br_taken     = vecs[i].bt;
            br_stall     = vecs[i].bs;
            br_target    = vecs[i].btgt;
            fs_valid     = vecs[i].fv;
            wb_flush     = vecs[i].fl;
            flush_target = vecs[i].ftgt;
            fs_allowin   = vecs[i].fa;
            inst_addr_ok = vecs[i].ok;
            inst_data_ok = vecs[i].dok;
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].rv, vecs[i].rd);
            @(posedge clk); #1;
        end

        // Streaming walk: one accept and one response every cycle.
        idle_inputs();
        resetn = 1;
        for (int i = 0; i < 6; i++) begin
            inst_addr_ok = 1; inst_data_ok = 1;
            @(negedge clk);
            chk_outs($sformatf("walk%0d", i), 1, B + 32'd4 + 32'(4 * i), 1, 0);
            @(posedge clk); #1;
        end

        // Reset dropped mid-cycle while a request is up.
        inst_addr_ok = 1; inst_data_ok = 0;
        #1;
        chk_outs("pre_async_rst", 1, B + 32'h1c, 0, 0);
        resetn = 0;
        inst_data_ok = 1;
        #1;
        chk_outs("async_rst", 0, B, 0, 0);
        @(posedge clk); #1;
        resetn = 1;
        inst_data_ok = 0;
        @(negedge clk);
        chk_outs("restart", 1, B, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
